// File: rtl/regfile_read_arbiter_pkg.sv
// Shared definitions for the register-file read arbiter slice.
// Holds the default widths of the 32-entry register file and the
// encoding of the read FSM.
package regfile_read_arbiter_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Requester-side bus of the register-file read arbiter.
//   req       : per-requester read request (level)
//   req_addr  : per-requester address, slice i = [i*ADDR_W +: ADDR_W]
//   gnt       : one-hot, one-cycle grant pulse
//   rsp_valid : one-cycle pulse, rsp_id/rsp_data valid
//   rsp_id    : index of the requester being answered
//   rsp_data  : captured read data
//   busy      : a read is in progress
// master = requester side, slave = arbiter side.
interface regfile_read_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  modport master (
    output req, req_addr,
    input  gnt, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req, req_addr,
    output gnt, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/regfile_read_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     : request vector
//   ptr     : index with the highest priority
//   winner  : first asserted request scanning ptr, ptr+1, ... mod NUM_REQ
//   any_req : at least one request asserted
// Shared with the write-port arbiter.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req[idx[ID_W-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: shares one register-file read port among NUM_REQ
// requesters. The port is a bank of 32-to-1 gate-level mux slices with a
// common select, so a read drives mux_sel, holds it SETTLE_CYCLES cycles
// for the slices to settle, captures mux_data and returns it with the
// requester index. Round-robin arbitration, one read in flight.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : requester bus (req/req_addr/gnt/rsp_*/busy), slave side
//   mux_sel    : registered common select to the mux slices
//   mux_data   : combined output of the mux slices
import regfile_read_arbiter_pkg::*;

module regfile_read_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDR_W        = RF_ADDR_W,
  parameter int unsigned DATA_W        = RF_DATA_W,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          ZERO_R0       = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_read_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]      mux_sel,
  input  logic [DATA_W-1:0]      mux_data
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     win_q, win_d;
  logic                zero_q, zero_d;
  logic [ADDR_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                vld_q, vld_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [ID_W-1:0]     pick_w;
  logic                pick_any;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .winner  (pick_w),
    .any_req (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      zero_q  <= 1'b0;
      sel_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      zero_q  <= zero_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    zero_d  = zero_q;
    sel_d   = sel_q;
    gnt_d   = '0;
    vld_d   = 1'b0;
    id_d    = id_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = NUM_REQ'(1) << pick_w;
          sel_d   = addr_arr[pick_w];
          win_d   = pick_w;
          zero_d  = (addr_arr[pick_w] == '0);
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          data_d  = (ZERO_R0 && zero_q) ? '0 : mux_data;
          id_d    = win_q;
          vld_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // The requester just served drops to the lowest priority.
        ptr_d   = (win_q == ID_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mux_sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter (NUM_REQ=4, SETTLE_CYCLES=2).
// A second instance with ZERO_R0=0 shares the stimulus so both zero-register
// behaviours are checked on every read.
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mux_data = '0;
  logic [4:0]  mux_sel, mux_sel_nz;

  int total = 0;
  int pass  = 0;
  int model_ptr = 0;

  regfile_read_arbiter_if #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(32)) bus ();
  regfile_read_arbiter_if #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(32)) bus_nz ();

  assign bus_nz.req      = bus.req;
  assign bus_nz.req_addr = bus.req_addr;

  regfile_read_arbiter #(
    .NUM_REQ(4), .ADDR_W(5), .DATA_W(32), .SETTLE_CYCLES(2), .ZERO_R0(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .mux_sel(mux_sel), .mux_data(mux_data)
  );

  regfile_read_arbiter #(
    .NUM_REQ(4), .ADDR_W(5), .DATA_W(32), .SETTLE_CYCLES(2), .ZERO_R0(1'b0)
  ) dut_nz (
    .clk(clk), .rst_n(rst_n), .bus(bus_nz.slave), .mux_sel(mux_sel_nz), .mux_data(mux_data)
  );

  always #5 clk = ~clk;

  // Reference arbitration: first set request scanning from the pointer.
  function automatic int model_pick(input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(model_ptr + k) % 4]) return (model_ptr + k) % 4;
    end
    return 0;
  endfunction

  // Issue requests in mask and follow ngr grants through to their responses.
  // hold=1 keeps every request asserted; otherwise a requester drops req
  // (and scrambles its address to X) once it sees its grant.
  task automatic serve(input logic [3:0] mask, input logic [19:0] addrs, input bit hold,
                       input int ngr, input bit fixed, input logic [31:0] fdata);
    logic [3:0]  cur;
    logic [4:0]  a [4];
    logic [31:0] d, exp_d;
    int cyc, w;
    cur = mask;
    for (int i = 0; i < 4; i++) a[i] = addrs[i*5 +: 5];
    bus.req = cur;
    bus.req_addr = addrs;
    cyc = 0;
    for (int g = 0; g < ngr; g++) begin
      do begin @(negedge clk); cyc++; end while (bus.gnt === 4'b0 && cyc < 20);
      if (bus.gnt === 4'b0) begin
        total++;
        $display("FAIL gnt_timeout: no grant after %0d cycles, req=%b", cyc, cur);
        break;
      end
      w = model_pick(cur);
      total++; if (bus.gnt !== 4'(1 << w)) $display("FAIL gnt: got %b want %b (req=%b)", bus.gnt, 4'(1 << w), cur); else pass++;
      total++; if (mux_sel !== a[w]) $display("FAIL mux_sel: got %0d want %0d", mux_sel, a[w]); else pass++;
      total++; if (bus.busy !== 1'b1) $display("FAIL busy_gnt: got %b want 1", bus.busy); else pass++;
      if (hold && g > 0) begin
        total++; if (cyc + 3 !== 4) $display("FAIL grant_spacing: got %0d want 4", cyc + 3); else pass++;
      end
      d = fixed ? fdata : $urandom;
      mux_data = d;
      if (!hold) begin
        cur[w] = 1'b0;
        bus.req = cur;
        bus.req_addr[w*5 +: 5] = 'x;
      end
      @(negedge clk);
      total++; if ({bus.gnt, bus.rsp_valid, bus.busy} !== 6'b000001)
        $display("FAIL settle: got gnt=%b vld=%b busy=%b want 0000/0/1", bus.gnt, bus.rsp_valid, bus.busy); else pass++;
      @(negedge clk);
      exp_d = (a[w] == 5'd0) ? 32'h0 : d;
      total++; if (bus.rsp_valid !== 1'b1) $display("FAIL rsp_valid: got %b want 1", bus.rsp_valid); else pass++;
      total++; if (bus.rsp_id !== 2'(w)) $display("FAIL rsp_id: got %0d want %0d", bus.rsp_id, w); else pass++;
      total++; if (bus.rsp_data !== exp_d) $display("FAIL rsp_data: got %h want %h", bus.rsp_data, exp_d); else pass++;
      total++; if (bus_nz.rsp_data !== d) $display("FAIL rsp_data_nz: got %h want %h", bus_nz.rsp_data, d); else pass++;
      total++; if ({bus.gnt, bus.busy} !== 5'b00001) $display("FAIL resp_state: got gnt=%b busy=%b want 0000/1", bus.gnt, bus.busy); else pass++;
      mux_data = $urandom;
      model_ptr = (w + 1) % 4;
      @(negedge clk);
      cyc = 0;
      total++; if ({bus.rsp_valid, bus.busy} !== 2'b00) $display("FAIL idle: got vld=%b busy=%b want 0/0", bus.rsp_valid, bus.busy); else pass++;
      total++; if (bus.rsp_data !== exp_d) $display("FAIL rsp_hold: got %h want %h", bus.rsp_data, exp_d); else pass++;
    end
    bus.req = '0;
  endtask

  task automatic test_reset();
    bus.req = '0;
    bus.req_addr = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({bus.gnt, mux_sel, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.busy} !== '0)
      $display("FAIL reset: gnt=%b sel=%0d vld=%b id=%0d data=%h busy=%b want all 0",
               bus.gnt, mux_sel, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.busy); else pass++;
    rst_n = 1'b1;
    model_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    serve(4'b0010, {5'd0, 5'd0, 5'd5, 5'd0}, 1'b0, 1, 1'b1, 32'hDEAD_BEEF);
  endtask

  task automatic test_simultaneous();
    serve(4'b1010, {5'd9, 5'd0, 5'd17, 5'd0}, 1'b0, 2, 1'b0, '0);
  endtask

  task automatic test_saturation();
    serve(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b1, 6, 1'b0, '0);
  endtask

  task automatic test_pointer_wrap();
    serve(4'b1000, {5'd12, 5'd0, 5'd0, 5'd0}, 1'b0, 1, 1'b0, '0);
    serve(4'b1001, {5'd13, 5'd0, 5'd0, 5'd14}, 1'b0, 2, 1'b0, '0);
  endtask

  task automatic test_zero_reg();
    serve(4'b0100, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0, 1, 1'b1, 32'hFFFF_FFFF);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bus.req = 4'b0010;
    bus.req_addr = {5'd0, 5'd0, 5'd7, 5'd0};
    mux_data = 32'h1234_5678;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (bus.gnt === 4'b0 && cyc < 20);
    total++; if (bus.gnt !== 4'b0010) $display("FAIL mid_gnt: got %b want 0010", bus.gnt); else pass++;
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({bus.gnt, mux_sel, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.busy} !== '0)
      $display("FAIL async_reset: gnt=%b sel=%0d vld=%b id=%0d data=%h busy=%b want all 0",
               bus.gnt, mux_sel, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.busy); else pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({bus.gnt, bus.rsp_valid} !== 5'b0) $display("FAIL reset_quiet: gnt=%b vld=%b want 0", bus.gnt, bus.rsp_valid); else pass++;
    end
    rst_n = 1'b1;
    model_ptr = 0;
    serve(4'b0100, {5'd0, 5'd21, 5'd0, 5'd0}, 1'b0, 1, 1'b0, '0);
  endtask

  task automatic test_random();
    logic [3:0]  mask;
    logic [19:0] addrs;
    for (int it = 0; it < 15; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++)
        addrs[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      serve(mask, addrs, 1'b0, $countones(mask), 1'b0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_saturation();
    test_pointer_wrap();
    test_zero_reg();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
